// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and fill-bit helper.
package shifter_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_SLL = 3'b000;
    localparam op_t OP_SRL = 3'b001;
    localparam op_t OP_SRA = 3'b010;
    localparam op_t OP_ROL = 3'b011;
    localparam op_t OP_ROR = 3'b100;

    // Bit shifted in at the top on a right shift: the original sign for SRA, zero otherwise.
    function automatic logic fill_bit(input op_t op, input logic sign);
        return (op == OP_SRA) ? sign : 1'b0;
    endfunction

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Operand/result handshake bundle for barrel_shifter_pipe.
interface barrel_shifter_pipe_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAGW  = 5
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [2:0]       in_op;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAGW-1:0]  out_tag;

    // Producer of operations and consumer of results.
    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    // The shifter itself.
    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/barrel_shifter_pipe_shift_stage.sv
// One combinational log2 step of the barrel shifter: shifts or rotates by STEP when enabled.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  op_t              op_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] data_o
);

    logic fill;

    // Apply this stage's step according to the op; pass-through when disabled or PASS.
    always_comb begin
        fill   = fill_bit(op_i, sign_i);
        data_o = data_i;
        if (en_i) begin
            case (op_i)
                OP_SLL:         data_o = {data_i[WIDTH-1-STEP:0], {STEP{1'b0}}};
                OP_SRL, OP_SRA: data_o = {{STEP{fill}}, data_i[WIDTH-1:STEP]};
                OP_ROL:         data_o = {data_i[WIDTH-1-STEP:0], data_i[WIDTH-1:WIDTH-STEP]};
                OP_ROR:         data_o = {data_i[STEP-1:0], data_i[WIDTH-1:STEP]};
                default:        data_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined multi-mode barrel shifter: one log2 step per register stage, largest step first,
// with valid/ready handshake, global stall and tag passthrough.
module barrel_shifter_pipe
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAGW  = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    barrel_shifter_pipe_if.slave bus
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic             stall;
    logic             adv;

    logic [WIDTH-1:0] data_q   [SHW];
    logic [SHW-1:0]   shamt_q  [SHW];
    op_t              op_q     [SHW];
    logic             sign_q   [SHW];
    logic [TAGW-1:0]  tag_q    [SHW];
    logic             valid_q  [SHW];

    logic [WIDTH-1:0] data_in  [SHW];
    logic [SHW-1:0]   shamt_in [SHW];
    op_t              op_in    [SHW];
    logic             sign_in  [SHW];
    logic [TAGW-1:0]  tag_in   [SHW];
    logic             valid_in [SHW];
    logic [WIDTH-1:0] data_d   [SHW];

    assign stall        = valid_q[SHW-1] & ~bus.out_ready;
    assign adv          = ~stall;
    assign bus.in_ready = adv;

    // Stage inputs: stage 0 sees the new operation, later stages see the previous register.
    always_comb begin
        data_in[0]  = bus.in_data;
        shamt_in[0] = bus.in_shamt;
        op_in[0]    = bus.in_op;
        sign_in[0]  = bus.in_data[WIDTH-1];
        tag_in[0]   = bus.in_tag;
        valid_in[0] = bus.in_valid;
        for (int unsigned k = 1; k < SHW; k++) begin
            data_in[k]  = data_q[k-1];
            shamt_in[k] = shamt_q[k-1];
            op_in[k]    = op_q[k-1];
            sign_in[k]  = sign_q[k-1];
            tag_in[k]   = tag_q[k-1];
            valid_in[k] = valid_q[k-1];
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .STEP  (1 << (SHW - 1 - k))
        ) u_stage (
            .data_i (data_in[k]),
            .en_i   (shamt_in[k][SHW-1-k]),
            .op_i   (op_in[k]),
            .sign_i (sign_in[k]),
            .data_o (data_d[k])
        );
    end

    // Pipeline registers: every stage advances together unless the result is stalled;
    // payload only loads alongside a valid bit so bubbles never disturb held data.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < SHW; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                shamt_q[k] <= '0;
                op_q[k]    <= OP_SLL;
                sign_q[k]  <= 1'b0;
                tag_q[k]   <= '0;
            end
        end else if (adv) begin
            for (int unsigned k = 0; k < SHW; k++) begin
                valid_q[k] <= valid_in[k];
                if (valid_in[k]) begin
                    data_q[k]  <= data_d[k];
                    shamt_q[k] <= shamt_in[k];
                    op_q[k]    <= op_in[k];
                    sign_q[k]  <= sign_in[k];
                    tag_q[k]   <= tag_in[k];
                end
            end
        end
    end

    assign bus.out_valid = valid_q[SHW-1];
    assign bus.out_data  = data_q[SHW-1];
    assign bus.out_tag   = tag_q[SHW-1];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed self-checking bench for barrel_shifter_pipe (WIDTH=32).
module tb_barrel_shifter_pipe;
    import shifter_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 5;
    localparam int          NV = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    barrel_shifter_pipe_if #(.WIDTH(W), .TAGW(TW)) bus ();

    barrel_shifter_pipe #(.WIDTH(W), .TAGW(TW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [2:0]  v_op    [NV] = '{OP_SLL, OP_SRA, OP_SRL, OP_SRA, OP_ROR, OP_ROL, OP_ROL, OP_ROR,
                                  OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR, 3'b111, 3'b101,
                                  OP_SRA, OP_ROR, OP_SRL};
    logic [31:0] v_data  [NV] = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h7FFFFFFF,
                                  32'h000000FF, 32'h80000001, 32'h12345678, 32'h12345678,
                                  32'hA5C30F96, 32'hA5C30F96, 32'hA5C30F96, 32'hA5C30F96,
                                  32'hA5C30F96, 32'hDEADBEEF, 32'hDEADBEEF, 32'h80000000,
                                  32'h80000001, 32'hFFFFFFFF};
    logic [4:0]  v_shamt [NV] = '{5'd31, 5'd4, 5'd4, 5'd31, 5'd4, 5'd1, 5'd8, 5'd24,
                                  5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd13, 5'd31, 5'd31,
                                  5'd31, 5'd31};
    logic [31:0] v_exp   [NV] = '{32'h80000000, 32'hF8000000, 32'h08000000, 32'h00000000,
                                  32'hF000000F, 32'h00000003, 32'h34567812, 32'h34567812,
                                  32'hA5C30F96, 32'hA5C30F96, 32'hA5C30F96, 32'hA5C30F96,
                                  32'hA5C30F96, 32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF,
                                  32'h00000003, 32'h00000001};

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 'x;
        bus.in_shamt  = '0;
        bus.in_op     = OP_SLL;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %0b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_out_data got %h want 00000000", bus.out_data);
        end
        checks++;
        if (bus.out_tag !== 5'd0) begin
            errors++;
            $display("FAIL reset_out_tag got %0d want 0", bus.out_tag);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0b want 1", bus.in_ready);
        end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_x_out_valid cycle %0d got %0b want 0", c, bus.out_valid);
            end
        end
        bus.in_data = '0;
    endtask

    task automatic test_directed();
        for (int i = 0; i < NV; i++) begin
            int cyc;
            bit seen;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.in_op     = v_op[i];
            bus.in_data   = v_data[i];
            bus.in_shamt  = v_shamt[i];
            bus.in_tag    = TW'(i);
            cyc  = 0;
            seen = 1'b0;
            while (!seen && cyc < 20) begin
                @(posedge clk);
                #1;
                cyc++;
                if (cyc == 1) bus.in_valid = 1'b0;
                if (bus.out_valid === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen || cyc != 5) begin
                errors++;
                $display("FAIL latency vec %0d got %0d cycles (seen %0b) want 5", i, cyc, seen);
            end
            checks++;
            if (bus.out_data !== v_exp[i]) begin
                errors++;
                $display("FAIL data vec %0d op %0d got %h want %h", i, v_op[i], bus.out_data, v_exp[i]);
            end
            checks++;
            if (bus.out_tag !== TW'(i)) begin
                errors++;
                $display("FAIL tag vec %0d got %0d want %0d", i, bus.out_tag, i);
            end
        end
    endtask

    task automatic test_back_to_back();
        int got   = 0;
        int first = -1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (got >= 8) begin
                    errors++;
                    $display("FAIL b2b_extra got tag %0d want no more results", bus.out_tag);
                end else begin
                    if (bus.out_tag !== TW'(got)) begin
                        errors++;
                        $display("FAIL b2b_tag got %0d want %0d", bus.out_tag, got);
                    end
                    checks++;
                    if (bus.out_data !== (32'(got + 1) << got)) begin
                        errors++;
                        $display("FAIL b2b_data idx %0d got %h want %h", got, bus.out_data, 32'(got + 1) << got);
                    end
                    if (first < 0) begin
                        first = c;
                    end else begin
                        checks++;
                        if (c != first + got) begin
                            errors++;
                            $display("FAIL b2b_gap idx %0d got cycle %0d want %0d", got, c, first + got);
                        end
                    end
                end
                got++;
            end
            if (c < 8) begin
                bus.in_valid = 1'b1;
                bus.in_op    = OP_SLL;
                bus.in_data  = 32'(c + 1);
                bus.in_shamt = 5'(c);
                bus.in_tag   = TW'(c);
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        checks++;
        if (got != 8) begin
            errors++;
            $display("FAIL b2b_count got %0d want 8", got);
        end
    endtask

    task automatic test_backpressure();
        int          n   = 12;
        int          src = 0;
        int          rcv = 0;
        logic [31:0] hd  = '0;
        logic [4:0]  ht  = '0;
        bit          fire_in;
        bit          fire_out;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_op     = OP_ROL;
        bus.in_data   = 32'(src + 1);
        bus.in_shamt  = 5'd4;
        bus.in_tag    = TW'(src);
        for (int c = 0; c < 60 && rcv < n; c++) begin
            @(negedge clk);
            fire_in  = bus.in_valid && bus.in_ready;
            fire_out = bus.out_valid && bus.out_ready;
            if (c >= 8 && c <= 10) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready cycle %0d got %0b want 0", c, bus.in_ready);
                end
                if (c == 8) begin
                    hd = bus.out_data;
                    ht = bus.out_tag;
                    checks++;
                    if (bus.out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL bp_full got out_valid %0b want 1", bus.out_valid);
                    end
                end else begin
                    checks++;
                    if (bus.out_valid !== 1'b1 || bus.out_data !== hd || bus.out_tag !== ht) begin
                        errors++;
                        $display("FAIL bp_stable cycle %0d got %0b/%h/%0d want 1/%h/%0d",
                                 c, bus.out_valid, bus.out_data, bus.out_tag, hd, ht);
                    end
                end
            end
            if (fire_out) begin
                checks++;
                if (bus.out_tag !== TW'(rcv) || bus.out_data !== (32'(rcv + 1) << 4)) begin
                    errors++;
                    $display("FAIL bp_result got %0d/%h want %0d/%h",
                             bus.out_tag, bus.out_data, rcv, 32'(rcv + 1) << 4);
                end
                rcv++;
            end
            if (fire_in) src++;
            @(posedge clk);
            #1;
            bus.out_ready = !((c + 1) >= 8 && (c + 1) <= 10);
            bus.in_valid  = (src < n);
            bus.in_data   = 32'(src + 1);
            bus.in_tag    = TW'(src);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (rcv != n) begin
            errors++;
            $display("FAIL bp_rcv_count got %0d want %0d", rcv, n);
        end
        checks++;
        if (src != n) begin
            errors++;
            $display("FAIL bp_src_count got %0d want %0d", src, n);
        end
    endtask

    task automatic test_reset_flush();
        int seen = 0;
        int cyc;
        bit done;
        bus.out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.in_op    = OP_SLL;
            bus.in_data  = 32'h0000000F;
            bus.in_shamt = 5'd1;
            bus.in_tag   = TW'(20 + j);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            errors++;
            $display("FAIL flush_outputs got %0b/%h want 0/00000000", bus.out_valid, bus.out_data);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_leak got %0d results want 0", seen);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_op    = OP_SRA;
        bus.in_data  = 32'hC0000000;
        bus.in_shamt = 5'd1;
        bus.in_tag   = 5'd9;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) bus.in_valid = 1'b0;
            if (bus.out_valid === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done || cyc != 5 || bus.out_data !== 32'hE0000000 || bus.out_tag !== 5'd9) begin
            errors++;
            $display("FAIL post_reset_op got %0b/%0d/%h/%0d want 1/5/e0000000/9",
                     done, cyc, bus.out_data, bus.out_tag);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
